seq_div: RTL

- Sequential restoring divider, one quotient bit per clock. It is the inverse of the team's shift-and-add price multiplier.
- Used in the vending datapath to split an accumulated amount (16-bit) by a unit price (12-bit). Produces the purchasable count (quotient) and the leftover change (remainder).
- Controlled by a start/busy/done handshake from the vending controller FSM.

---
 rtl/seq_arith_pkg.sv | 21 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_div.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential multiplier and divider:
// FSM state encoding, default operand widths and step counter sizing.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 12;

  // Width of a counter running 0..w-1, never narrower than one bit.
  function automatic int step_cw(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_STEP_CW = step_cw(DEF_DW);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int VW = 12
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  logic [VW:0] t;
  logic [VW:0] div_ext;
  // The partial remainder stays below the divisor between steps, so its
  // top bit is always 0 and does not take part in the shifted value.
  logic        unused_r_msb;

  assign unused_r_msb = r_i[VW];
  assign t            = {r_i[VW-1:0], q_msb_i};
  assign div_ext      = {1'b0, divisor_i};

  // Compare and conditionally subtract.
  always_comb begin
    q_bit_o = 1'b0;
    r_o     = t;
    if (t >= div_ext) begin
      q_bit_o = 1'b1;
      r_o     = t - div_ext;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Divide-by-zero finishes immediately with an
// all-ones quotient and a sticky flag.
module seq_div
  import seq_arith_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_div_zero,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder
);

  localparam int CW = step_cw(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] div_q, div_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   r_nxt;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[DW-1]),
    .divisor_i (div_q),
    .r_o       (r_nxt),
    .q_bit_o   (q_bit)
  );

  // Next-state logic: start acceptance, step sequencing, result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      RUN: begin
        r_d   = r_nxt;
        q_d   = {q_q[DW-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          quot_d  = {q_q[DW-2:0], q_bit};
          rem_d   = r_nxt[VW-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: ;
    endcase

    // IDLE and DONE both accept a new operation; DONE allows back-to-back.
    if ((state_q == IDLE || state_q == DONE) && i_start) begin
      div_d = i_divisor;
      q_d   = i_dividend;
      r_d   = '0;
      cnt_d = '0;
      rem_d = '0;
      if (i_divisor == '0) begin
        quot_d  = '1;
        dz_d    = 1'b1;
        state_d = DONE;
      end else begin
        quot_d  = '0;
        dz_d    = 1'b0;
        state_d = RUN;
      end
    end

    // Clear wins over everything, including a simultaneous start.
    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      r_d     = '0;
      q_d     = '0;
      div_d   = '0;
      quot_d  = '0;
      rem_d   = '0;
      dz_d    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign o_busy      = (state_q == RUN);
  assign o_done      = (state_q == DONE);
  assign o_div_zero  = dz_q;
  assign o_quotient  = quot_q;
  assign o_remainder = rem_q;

endmodule
